// File: rtl/dac_pkg.sv
// Shared definitions for the PWM / sigma-delta DAC array: mode encoding and
// the period reload computation.
package dac_pkg;

  typedef enum logic {
    MODE_PWM = 1'b0,
    MODE_SD  = 1'b1
  } dac_mode_e;

  // Reload value of the shared period counter; the counter runs 0..ARR.
  function automatic int calc_arr(input int clk_freq, input int pwm_freq);
    return (clk_freq / pwm_freq) - 1;
  endfunction

endpackage

// File: rtl/dac_channel.sv
// One modulator channel: amplitude shadow/active pair, PWM compare against the
// shared counter, and a first-order sigma-delta accumulator.
module dac_channel
  import dac_pkg::*;
#(
  parameter int AM_WIDTH = 8,
  parameter int CNT_W    = 8,
  parameter int PERIOD   = 240
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                wrap_i,
  input  logic                wr_en_i,
  input  logic [AM_WIDTH-1:0] am_i,
  input  logic [CNT_W-1:0]    cnt_i,
  input  dac_mode_e           mode_i,
  output logic                pwm_o
);

  // Product width covers (2^AM_WIDTH - 1) * PERIOD without overflow.
  localparam int PROD_W = AM_WIDTH + $clog2(PERIOD + 1);

  logic [AM_WIDTH-1:0] shadow_q, shadow_d;
  logic [AM_WIDTH-1:0] active_q, active_d;
  logic [AM_WIDTH-1:0] acc_q, acc_d;
  logic                pwm_q, pwm_d;

  logic [PROD_W-1:0]   prod;
  logic [PROD_W-1:0]   ccr;
  logic [PROD_W-1:0]   cnt_ext;
  logic [AM_WIDTH:0]   sum;

  assign prod    = PROD_W'(active_q) * PROD_W'(PERIOD);
  assign ccr     = prod >> AM_WIDTH;
  assign cnt_ext = PROD_W'(cnt_i);
  assign sum     = {1'b0, acc_q} + {1'b0, active_q};

  // The accumulator runs in both modes so it only depends on active and en.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    acc_d    = acc_q;
    pwm_d    = 1'b0;
    if (wr_en_i) begin
      shadow_d = am_i;
    end
    if (wrap_i) begin
      active_d = shadow_q;
    end
    if (!en_i) begin
      acc_d = '0;
    end else begin
      acc_d = sum[AM_WIDTH-1:0];
      pwm_d = (mode_i == MODE_SD) ? sum[AM_WIDTH] : (cnt_ext < ccr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      acc_q    <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      acc_q    <= acc_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_dac_array.sv
// Multi-channel PWM / sigma-delta DAC: shared period counter, write handshake
// and period_start pulse; per-channel modulators live in dac_channel.
module pwm_dac_array
  import dac_pkg::*;
#(
  parameter int CLK_FREQ  = 120_000_000,
  parameter int PWM_FREQ  = 500_000,
  parameter int AM_WIDTH  = 8,
  parameter int CHANNELS  = 4,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic                am_valid,
  output logic                am_ready,
  input  logic [CH_W-1:0]     am_ch,
  input  logic [AM_WIDTH-1:0] am,
  output logic [CHANNELS-1:0] pwm,
  output logic                period_start
);

  localparam int ARR   = calc_arr(CLK_FREQ, PWM_FREQ);
  localparam int CNT_W = (ARR > 0) ? $clog2(ARR + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  dac_mode_e        mode_q, mode_d;
  logic             period_start_q;
  logic             at_arr;
  logic             wrap;
  logic             wr_accept;

  assign at_arr    = (cnt_q == CNT_W'(ARR));
  assign wrap      = en && at_arr;
  // Writes are refused on the wrap cycle so shadow never changes while it is copied.
  assign am_ready  = ~wrap;
  assign wr_accept = am_valid && am_ready;

  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (!en) begin
      cnt_d = '0;
    end else if (at_arr) begin
      cnt_d  = '0;
      mode_d = mode ? MODE_SD : MODE_PWM;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      mode_q         <= MODE_PWM;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      mode_q         <= mode_d;
      period_start_q <= wrap;
    end
  end

  assign period_start = period_start_q;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic ch_wr;
    assign ch_wr = wr_accept && (am_ch == CH_W'(gi));

    dac_channel #(
      .AM_WIDTH (AM_WIDTH),
      .CNT_W    (CNT_W),
      .PERIOD   (ARR + 1)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en_i    (en),
      .wrap_i  (wrap),
      .wr_en_i (ch_wr),
      .am_i    (am),
      .cnt_i   (cnt_q),
      .mode_i  (mode_q),
      .pwm_o   (pwm[gi])
    );
  end

endmodule

// File: tb/tb_pwm_dac_array.sv
// Directed + randomized bench for pwm_dac_array against an integer reference
// model of the period counter, shadow/active amplitudes and modulators.
module tb_pwm_dac_array;

  localparam int CH     = 4;
  localparam int AM_W   = 8;
  localparam int CH_W   = 2;
  localparam int ARR    = 120_000_000 / 500_000 - 1;
  localparam int PERIOD = ARR + 1;
  localparam int SCALE  = 1 << AM_W;

  logic            clk;
  logic            rst;
  logic            en;
  logic            mode;
  logic            am_valid;
  logic            am_ready;
  logic [CH_W-1:0] am_ch;
  logic [AM_W-1:0] am;
  logic [CH-1:0]   pwm;
  logic            period_start;

  pwm_dac_array #(
    .CLK_FREQ (120_000_000),
    .PWM_FREQ (500_000),
    .AM_WIDTH (AM_W),
    .CHANNELS (CH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .am_valid     (am_valid),
    .am_ready     (am_ready),
    .am_ch        (am_ch),
    .am           (am),
    .pwm          (pwm),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // reference model state
  int       m_cnt;
  int       m_shadow [CH];
  int       m_active [CH];
  int       m_acc    [CH];
  int       m_mode;
  logic [CH-1:0] exp_pwm;
  logic     exp_ps;

  bit g_en;
  bit g_mode;
  int hi [CH];

  task automatic model_reset();
    m_cnt = 0;
    m_mode = 0;
    for (int c = 0; c < CH; c++) begin
      m_shadow[c] = 0;
      m_active[c] = 0;
      m_acc[c]    = 0;
    end
    exp_pwm = '0;
    exp_ps  = 1'b0;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, expv);
    end
  endtask

  // One clock: drive inputs, check am_ready, clock, advance model, check outputs.
  task automatic step(input bit en_v, input bit mode_v, input bit valid_v,
                      input int ch_v, input int am_v);
    bit exp_ready;
    bit wrap;
    int sum;
    en       = en_v;
    mode     = mode_v;
    am_valid = valid_v;
    am_ch    = ch_v[CH_W-1:0];
    am       = am_v[AM_W-1:0];
    #1;
    exp_ready = !(en_v && m_cnt == ARR);
    check_bit("am_ready", am_ready, exp_ready);
    @(posedge clk);
    wrap = en_v && (m_cnt == ARR);
    for (int c = 0; c < CH; c++) begin
      if (!en_v) begin
        exp_pwm[c] = 1'b0;
        m_acc[c]   = 0;
      end else begin
        sum = m_acc[c] + m_active[c];
        if (m_mode == 1) exp_pwm[c] = (sum >= SCALE);
        else             exp_pwm[c] = (m_cnt < (m_active[c] * PERIOD) / SCALE);
        m_acc[c] = sum % SCALE;
      end
    end
    if (valid_v && exp_ready && ch_v < CH) m_shadow[ch_v] = am_v;
    if (wrap) begin
      for (int c = 0; c < CH; c++) m_active[c] = m_shadow[c];
      m_mode = mode_v;
    end
    exp_ps = wrap;
    m_cnt  = (!en_v || wrap) ? 0 : m_cnt + 1;
    #1;
    vectors++;
    assert (pwm === exp_pwm) else begin
      miscompares++;
      $error("FAIL pwm t=%0t observed=%b expected=%b", $time, pwm, exp_pwm);
    end
    check_bit("period_start", period_start, exp_ps);
  endtask

  // Idle steps, counting high cycles per channel; optional 1-in-4 gap check on ch2.
  task automatic run_n(input int n, input bit gap_chk);
    int last;
    last = -1;
    for (int c = 0; c < CH; c++) hi[c] = 0;
    for (int i = 0; i < n; i++) begin
      step(g_en, g_mode, 1'b0, 0, 0);
      for (int c = 0; c < CH; c++) if (pwm[c] === 1'b1) hi[c]++;
      if (gap_chk && pwm[2] === 1'b1) begin
        if (last >= 0) check_int("sd_gap_ch2", i - last, 4);
        last = i;
      end
    end
  endtask

  task automatic run_to_wrap();
    bit hit;
    bit was_wrap;
    hit = 1'b0;
    for (int k = 0; k < 2 * PERIOD && !hit; k++) begin
      was_wrap = g_en && (m_cnt == ARR);
      step(g_en, g_mode, 1'b0, 0, 0);
      hit = was_wrap;
    end
    if (!hit) begin
      miscompares++;
      $error("FAIL run_to_wrap bound expired observed=no_wrap expected=wrap");
    end
  endtask

  task automatic run_until_cnt(input int target);
    for (int k = 0; k < 2 * PERIOD && m_cnt != target; k++)
      step(g_en, g_mode, 1'b0, 0, 0);
    check_int("reach_cnt", m_cnt, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; am_valid = 1'b0; am_ch = '0; am = '0;
    model_reset();
    g_en = 1'b1; g_mode = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_int("reset_pwm", int'(pwm), 0);
    check_bit("reset_period_start", period_start, 1'b0);
    check_bit("reset_am_ready", am_ready, 1'b1);
    rst = 1'b0;

    // PWM, ch0 = 128: half-duty from the second period on
    step(1, 0, 1, 0, 128);
    run_to_wrap();
    run_n(PERIOD, 0);
    check_int("ch0_128_hi", hi[0], 120);
    check_int("ch1_idle_hi", hi[1], 0);
    check_int("ch2_idle_hi", hi[2], 0);
    check_int("ch3_idle_hi", hi[3], 0);

    // Refused write on the wrap cycle that is never retried must vanish
    run_until_cnt(ARR);
    step(1, 0, 1, 3, 100);
    // Refused write on the wrap cycle, retried next cycle
    run_until_cnt(ARR);
    step(1, 0, 1, 1, 255);
    step(1, 0, 1, 1, 255);
    run_to_wrap();
    run_n(PERIOD, 0);
    check_int("ch1_255_hi", hi[1], 239);
    check_int("ch0_keep_hi", hi[0], 120);
    check_int("ch3_refused_hi", hi[3], 0);

    // Sigma-delta, ch2 = 64 then 0
    g_mode = 1'b1;
    step(1, 1, 1, 2, 64);
    run_to_wrap();
    run_n(PERIOD, 1);
    check_int("sd_ch2_64_hi", hi[2], 60);
    step(1, 1, 1, 2, 0);
    run_to_wrap();
    run_n(PERIOD, 0);
    check_int("sd_ch2_0_hi", hi[2], 0);

    // Mode toggled mid-period keeps SD until the next wrap
    run_n(60, 0);
    g_mode = 1'b0;
    run_n(100, 0);
    check_int("toggle_sd_ch0_hi", hi[0], 50);
    run_to_wrap();
    run_n(PERIOD, 0);
    check_int("toggle_pwm_ch0_hi", hi[0], 120);
    check_bit("toggle_period_start", period_start, 1'b1);

    // en low for 100 cycles with a write to ch3
    run_n(30, 0);
    g_en = 1'b0;
    step(0, 0, 1, 3, 200);
    run_n(99, 0);
    check_int("en_low_ch0_hi", hi[0], 0);
    check_int("en_low_ch1_hi", hi[1], 0);
    g_en = 1'b1;
    run_n(PERIOD, 0);
    check_int("en_back_ch3_old_hi", hi[3], 0);
    check_int("en_back_ch0_hi", hi[0], 120);
    run_n(PERIOD, 0);
    check_int("en_back_ch3_new_hi", hi[3], 187);

    // Asynchronous reset at cnt = 57 while pwm[0] is high
    run_until_cnt(57);
    check_bit("pre_rst_pwm0", pwm[0], 1'b1);
    rst = 1'b1;
    #1;
    check_int("async_rst_pwm", int'(pwm), 0);
    check_bit("async_rst_period_start", period_start, 1'b0);
    check_bit("async_rst_am_ready", am_ready, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    run_n(PERIOD, 0);
    check_int("post_rst_ch0_hi", hi[0], 0);
    check_int("post_rst_ch1_hi", hi[1], 0);
    check_int("post_rst_ch3_hi", hi[3], 0);
    check_bit("post_rst_first_wrap", period_start, 1'b1);

    // Randomized traffic against the model
    for (int r = 0; r < 2000; r++) begin
      if (r % 250 == 0) g_mode = 1'($urandom_range(0, 1));
      g_en = !(r >= 900 && r < 950);
      step(g_en, g_mode, ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, CH - 1)), int'($urandom_range(0, SCALE - 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
